hist_sequencer: RTL and testbench



---
 rtl/hist_seq_pkg.sv | 32 +++
 rtl/hist_accum.sv | 66 ++++++
 rtl/hist_sequencer.sv | 133 +++++++++++++
 tb/tb_hist_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hist_seq_pkg.sv
// hist_seq_pkg: shared types and helpers for the
// time-multiplexed magnitude histogram sequencer.
package hist_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_COUNT,
    ST_REPORT
  } state_e;

  typedef struct packed {
    logic lo;
    logic hi;
  } mag_t;

  // 01/10 are low magnitude, 00/11 are high magnitude
  function automatic mag_t mag_decode(input logic [1:0] s);
    mag_t m;
    m.lo = s[1] ^ s[0];
    m.hi = ~(s[1] ^ s[0]);
    return m;
  endfunction

  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/hist_accum.sv
// hist_accum: low/high magnitude counter pair over one
// window, with scaled and saturated result views.
module hist_accum
  import hist_seq_pkg::*;
#(
  parameter int WIN_LOG2 = 19,
  parameter int OUT_W    = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             en,
  input  logic [1:0]       sample,
  output logic             done,
  output logic [OUT_W-1:0] h0,
  output logic [OUT_W-1:0] h1
);

  localparam int SH = WIN_LOG2 - OUT_W;

  logic [WIN_LOG2:0]   c0_q, c0_d;
  logic [WIN_LOG2:0]   c1_q, c1_d;
  logic [WIN_LOG2-1:0] win_q, win_d;
  logic [WIN_LOG2:0]   s0, s1;
  mag_t                m;

  always_comb begin
    m     = mag_decode(sample);
    c0_d  = c0_q;
    c1_d  = c1_q;
    win_d = win_q;
    if (clear) begin
      c0_d  = '0;
      c1_d  = '0;
      win_d = '0;
    end else if (en) begin
      c0_d  = c0_q + (WIN_LOG2+1)'(m.lo);
      c1_d  = c1_q + (WIN_LOG2+1)'(m.hi);
      win_d = win_q + WIN_LOG2'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c0_q  <= '0;
      c1_q  <= '0;
      win_q <= '0;
    end else begin
      c0_q  <= c0_d;
      c1_q  <= c1_d;
      win_q <= win_d;
    end
  end

  assign done = en & (&win_q);

  // Views use next-state counts so the final sample is included
  assign s0 = c0_d >> SH;
  assign s1 = c1_d >> SH;

  assign h0 = (s0[WIN_LOG2:OUT_W] != '0) ? '1
            : s0[OUT_W-1:0];
  assign h1 = (s1[WIN_LOG2:OUT_W] != '0) ? '1
            : s1[OUT_W-1:0];

endmodule

// File: rtl/hist_sequencer.sv
// hist_sequencer: schedules one histogram accumulator
// across NCH channels and offers each result via valid/ready.
module hist_sequencer
  import hist_seq_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int WIN_LOG2 = 19,
  parameter int OUT_W    = 8,
  parameter int SETTLE   = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [2*NCH-1:0]         x,
  input  logic                     enable,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic [clog2(NCH)-1:0]    result_ch,
  output logic [OUT_W-1:0]         result_h0,
  output logic [OUT_W-1:0]         result_h1,
  output logic                     busy
);

  localparam int CW = clog2(NCH);
  localparam int SW = clog2(SETTLE + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    ch_q, ch_d;
  logic [SW-1:0]    set_q, set_d;
  logic [CW-1:0]    rch_q, rch_d;
  logic [OUT_W-1:0] rh0_q, rh0_d;
  logic [OUT_W-1:0] rh1_q, rh1_d;

  logic [1:0]       sample;
  logic             acc_clear;
  logic             acc_en;
  logic             acc_done;
  logic [OUT_W-1:0] acc_h0;
  logic [OUT_W-1:0] acc_h1;
  logic [CW-1:0]    ch_next;

  always_comb begin
    sample = '0;
    for (int k = 0; k < NCH; k++) begin
      if (ch_q == CW'(k)) sample = x[2*k +: 2];
    end
  end

  assign acc_en    = (state_q == ST_COUNT);
  assign acc_clear = ~acc_en;

  hist_accum #(
    .WIN_LOG2 (WIN_LOG2),
    .OUT_W    (OUT_W)
  ) u_accum (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (acc_clear),
    .en      (acc_en),
    .sample  (sample),
    .done    (acc_done),
    .h0      (acc_h0),
    .h1      (acc_h1)
  );

  assign ch_next = (ch_q == CW'(NCH-1)) ? '0
                 : ch_q + CW'(1);

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    set_d   = '0;
    rch_d   = rch_q;
    rh0_d   = rh0_q;
    rh1_d   = rh1_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (set_q == SW'(SETTLE-1)) begin
          state_d = ST_COUNT;
        end else begin
          set_d = set_q + SW'(1);
        end
      end
      ST_COUNT: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (acc_done) begin
          state_d = ST_REPORT;
          rch_d   = ch_q;
          rh0_d   = acc_h0;
          rh1_d   = acc_h1;
        end
      end
      ST_REPORT: begin
        // enable only decides where to go after the transfer
        if (result_ready) begin
          ch_d    = ch_next;
          state_d = enable ? ST_SETTLE : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
      set_q   <= '0;
      rch_q   <= '0;
      rh0_q   <= '0;
      rh1_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      set_q   <= set_d;
      rch_q   <= rch_d;
      rh0_q   <= rh0_d;
      rh1_q   <= rh1_d;
    end
  end

  assign result_valid = (state_q == ST_REPORT);
  assign busy         = (state_q != ST_IDLE);
  assign result_ch    = rch_q;
  assign result_h0    = rh0_q;
  assign result_h1    = rh1_q;

endmodule

// File: tb/tb_hist_sequencer.sv
// tb_hist_sequencer: table vectors, hand sequences and
// random windows checked against a window-sum model.
module tb_hist_sequencer;

  localparam int NCH  = 4;
  localparam int WL   = 4;
  localparam int OW   = 4;
  localparam int ST   = 2;
  localparam int W    = 1 << WL;
  localparam int HMAX = (1 << OW) - 1;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       result_ready;
  logic       result_valid;
  logic       busy;
  logic [7:0] x;
  logic [1:0] result_ch;
  logic [3:0] result_h0;
  logic [3:0] result_h1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int es    = 0;
  int exp_ch = 0;
  int eh0 = 0;
  int eh1 = 0;
  int pat_ch = -1;
  logic [1:0] pa = 2'b00;
  logic [1:0] pb = 2'b00;
  logic [7:0] xlog [int];

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic       en_after;
    int         hold;
    int         h0;
    int         h1;
  } vec_t;

  vec_t tbl [6];

  hist_sequencer #(
    .NCH      (NCH),
    .WIN_LOG2 (WL),
    .OUT_W    (OW),
    .SETTLE   (ST)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .x            (x),
    .enable       (enable),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_ch    (result_ch),
    .result_h0    (result_h0),
    .result_h1    (result_h1),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act,
                     input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic drive_x();
    logic [7:0] nx;
    nx = 8'($urandom);
    if (pat_ch >= 0) nx[2*pat_ch +: 2] = cyc[0] ? pb : pa;
    x = nx;
  endtask

  // xlog[n] is the input seen by the DUT at edge n
  task automatic step();
    @(posedge clk);
    cyc++;
    xlog[cyc] = x;
    #1;
    drive_x();
  endtask

  task automatic model_window(input int s_edge, input int ch);
    int lows;
    logic [7:0] v;
    logic [1:0] s;
    lows = 0;
    for (int n = s_edge + ST + 1; n <= s_edge + ST + W; n++) begin
      v = xlog[n];
      s = v[2*ch +: 2];
      if (s == 2'b01 || s == 2'b10) lows++;
    end
    eh0 = (lows > HMAX) ? HMAX : lows;
    eh1 = ((W - lows) > HMAX) ? HMAX : (W - lows);
  endtask

  task automatic wait_result(input int s_edge, input string tag);
    int n;
    n = 0;
    while (!result_valid && n < 100) begin
      step();
      n++;
    end
    if (!result_valid) begin
      chk({tag, " timeout"}, 0, 1);
      return;
    end
    chk({tag, " latency"}, cyc, s_edge + ST + W);
    model_window(s_edge, exp_ch);
    chk({tag, " ch"}, int'(result_ch), exp_ch);
    chk({tag, " h0"}, int'(result_h0), eh0);
    chk({tag, " h1"}, int'(result_h1), eh1);
  endtask

  task automatic xfer(input int hold, input logic en_hold,
                      output int t);
    enable = en_hold;
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold", int'({result_valid, busy, result_ch,
                        result_h0, result_h1}),
          int'({1'b1, 1'b1, 2'(exp_ch), 4'(eh0), 4'(eh1)}));
    end
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    t = cyc;
    exp_ch = (exp_ch + 1) % NCH;
    chk("post valid", int'(result_valid), 0);
    chk("post busy", int'(busy), int'(en_hold));
  endtask

  initial begin
    logic en_h;
    tbl[0] = '{2'b01, 2'b01, 1'b1, 0, 15, 0};
    tbl[1] = '{2'b00, 2'b10, 1'b1, 0, 8, 8};
    tbl[2] = '{2'b11, 2'b00, 1'b1, 1, 0, 15};
    tbl[3] = '{2'b10, 2'b01, 1'b1, 0, 15, 0};
    tbl[4] = '{2'b11, 2'b01, 1'b1, 2, 8, 8};
    tbl[5] = '{2'b10, 2'b11, 1'b0, 3, 8, 8};

    reset_n = 1'b0;
    enable = 1'b0;
    result_ready = 1'b0;
    x = '0;
    repeat (3) step();
    chk("reset outs", int'({result_valid, busy, result_ch,
                            result_h0, result_h1}), 0);
    reset_n = 1'b1;
    step();

    // Table: channels 0,1,2,3,0,1; last one drops enable in REPORT
    enable = 1'b1;
    es = cyc + 1;
    for (int i = 0; i < 6; i++) begin
      pat_ch = exp_ch;
      pa = tbl[i].a;
      pb = tbl[i].b;
      wait_result(es, "tbl");
      chk("tbl h0 const", int'(result_h0), tbl[i].h0);
      chk("tbl h1 const", int'(result_h1), tbl[i].h1);
      xfer(tbl[i].hold, tbl[i].en_after, es);
    end
    pat_ch = -1;

    result_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle ready ignored",
          int'({result_valid, busy}), 0);
    end
    result_ready = 1'b0;

    enable = 1'b1;
    es = cyc + 1;
    wait_result(es, "ch2");
    xfer(0, 1'b1, es);

    // Abort channel 3 on its fifth COUNT cycle
    repeat (ST + 4) step();
    enable = 1'b0;
    step();
    chk("abort busy", int'(busy), 0);
    for (int i = 0; i < 25; i++) begin
      step();
      chk("abort no valid", int'(result_valid), 0);
    end
    enable = 1'b1;
    es = cyc + 1;
    wait_result(es, "reenable");
    xfer(0, 1'b1, es);

    wait_result(es, "bp");
    xfer(50, 1'b1, es);
    wait_result(es, "bp next");
    xfer(0, 1'b1, es);

    for (int i = 0; i < 10; i++) begin
      wait_result(es, "rnd");
      en_h = ($urandom_range(0, 3) != 0);
      xfer($urandom_range(0, 6), en_h, es);
      if (!en_h) begin
        repeat ($urandom_range(1, 4)) step();
        enable = 1'b1;
        es = cyc + 1;
      end
    end

    for (int i = 0; i < NCH && exp_ch != 2; i++) begin
      wait_result(es, "to ch2");
      xfer(0, 1'b1, es);
    end

    // Asynchronous reset in the middle of channel 2's window
    repeat (ST + 6) step();
    reset_n = 1'b0;
    #1;
    chk("async reset", int'({result_valid, busy, result_ch,
                             result_h0, result_h1}), 0);
    step();
    chk("reset held", int'({result_valid, busy, result_ch,
                            result_h0, result_h1}), 0);
    reset_n = 1'b1;
    exp_ch = 0;
    es = cyc + 1;
    wait_result(es, "post reset");
    xfer(0, 1'b0, es);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
